// File: rtl/debug_cmd_pkg.sv
// Shared defaults and types for the system-clock side of the CPU JTAG debug slave.
package debug_cmd_pkg;

  localparam int SR_W_DEF        = 38;
  localparam int IR_W_DEF        = 2;
  localparam int ACT_BIT_DEF     = 35;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int FIFO_DEPTH_DEF  = 4;

  localparam int NUM_CMD = 2 ** IR_W_DEF;
  localparam int LEVEL_W = $clog2(FIFO_DEPTH_DEF) + 1;

  typedef struct packed {
    logic [IR_W_DEF-1:0] ir;
    logic [SR_W_DEF-1:0] sr;
  } dbg_cmd_t;

  typedef logic [SYNC_STAGES_DEF-1:0] sync_vec_t;

endpackage

// File: rtl/debug_cmd_sysclk_bridge_if.sv
// Command-side bundle between the bridge (master) and the OCI consumer logic (slave).
interface debug_cmd_sysclk_bridge_if
  import debug_cmd_pkg::*;
#(
  parameter int SR_W       = SR_W_DEF,
  parameter int IR_W       = IR_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
);
  localparam int LANES = 2 ** IR_W;
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              overflow_clr;
  logic              overflow;
  logic [SR_W-1:0]   jdo;
  logic [IR_W-1:0]   jir;
  logic [LANES-1:0]  take_action;
  logic [LANES-1:0]  take_no_action;
  logic [LVL_W-1:0]  fifo_level;

  modport master (
    input  cmd_ready, overflow_clr,
    output cmd_valid, jdo, jir, take_action, take_no_action, fifo_level, overflow
  );

  modport slave (
    output cmd_ready, overflow_clr,
    input  cmd_valid, jdo, jir, take_action, take_no_action, fifo_level, overflow
  );

endinterface

// File: rtl/dbg_cmd_fifo.sv
// Small synchronous FIFO; pushes while full are ignored unless a pop frees the slot.
module dbg_cmd_fifo #(
  parameter int W     = 40,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wr_data,
  output logic [W-1:0]               rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [W-1:0]     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r, rd_ptr_r;
  logic [LVL_W-1:0] level_r, level_nxt_s;
  logic             we_s, re_s;

  assign full    = (level_r == LVL_W'(DEPTH));
  assign empty   = (level_r == '0);
  assign re_s    = pop & ~empty;
  assign we_s    = push & (~full | re_s);
  assign rd_data = mem_r[rd_ptr_r];
  assign level   = level_r;

  // Occupancy bookkeeping for the four push/pop combinations
  always_comb begin
    level_nxt_s = level_r;
    case ({we_s, re_s})
      2'b10:   level_nxt_s = level_r + LVL_W'(1);
      2'b01:   level_nxt_s = level_r - LVL_W'(1);
      default: level_nxt_s = level_r;
    endcase
  end

  // Pointer and level registers; pointers wrap naturally as DEPTH is a power of two
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
    end else begin
      if (we_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (re_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      level_r <= level_nxt_s;
    end
  end

  // Storage array
  always_ff @(posedge clk) begin
    if (we_s) mem_r[wr_ptr_r] <= wr_data;
  end

endmodule

// File: rtl/debug_cmd_sysclk_bridge.sv
// Synchronises update-IR/DR from the TCK domain, queues {ir, sr} commands and
// issues per-instruction action strobes with a held jdo/jir word on each pop.
module debug_cmd_sysclk_bridge
  import debug_cmd_pkg::*;
#(
  parameter int SR_W        = SR_W_DEF,
  parameter int IR_W        = IR_W_DEF,
  parameter int ACT_BIT     = ACT_BIT_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FIFO_DEPTH  = FIFO_DEPTH_DEF
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [IR_W-1:0]             ir_in,
  input  logic [SR_W-1:0]             sr,
  input  logic                        vs_uir,
  input  logic                        vs_udr,
  debug_cmd_sysclk_bridge_if.master   cmd_if
);
  localparam int LANES = 2 ** IR_W;
  localparam int CMD_W = IR_W + SR_W;

  logic [SYNC_STAGES-1:0]      uir_sync_r, udr_sync_r;
  logic                        uir_prev_r, udr_prev_r;
  logic                        uir_evt_s, udr_evt_s;
  logic [IR_W-1:0]             ir_reg_r, ir_sel_s;
  logic [CMD_W-1:0]            head_s;
  logic [IR_W-1:0]             head_ir_s;
  logic [SR_W-1:0]             head_sr_s;
  logic                        full_s, empty_s, pop_s, drop_s;
  logic [$clog2(FIFO_DEPTH):0] level_s;
  logic [LANES-1:0]            act_nxt_s, noact_nxt_s;

  // Synchronisers and edge-detect history; reset high so a held level is not an event
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      uir_sync_r <= '1;
      udr_sync_r <= '1;
      uir_prev_r <= 1'b1;
      udr_prev_r <= 1'b1;
    end else begin
      uir_sync_r <= {uir_sync_r[SYNC_STAGES-2:0], vs_uir};
      udr_sync_r <= {udr_sync_r[SYNC_STAGES-2:0], vs_udr};
      uir_prev_r <= uir_sync_r[SYNC_STAGES-1];
      udr_prev_r <= udr_sync_r[SYNC_STAGES-1];
    end
  end

  assign uir_evt_s = uir_sync_r[SYNC_STAGES-1] & ~uir_prev_r;
  assign udr_evt_s = udr_sync_r[SYNC_STAGES-1] & ~udr_prev_r;
  // A DR update landing with an IR update uses the fresh instruction
  assign ir_sel_s  = uir_evt_s ? ir_in : ir_reg_r;

  // Instruction register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ir_reg_r <= '0;
    end else if (uir_evt_s) begin
      ir_reg_r <= ir_in;
    end
  end

  assign pop_s  = ~empty_s & cmd_if.cmd_ready;
  assign drop_s = udr_evt_s & full_s & ~pop_s;

  dbg_cmd_fifo #(
    .W     (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (udr_evt_s),
    .pop     (pop_s),
    .wr_data ({ir_sel_s, sr}),
    .rd_data (head_s),
    .full    (full_s),
    .empty   (empty_s),
    .level   (level_s)
  );

  assign head_ir_s = head_s[CMD_W-1:SR_W];
  assign head_sr_s = head_s[SR_W-1:0];

  // One-hot lane decode of the command being popped
  always_comb begin
    act_nxt_s   = '0;
    noact_nxt_s = '0;
    if (pop_s) begin
      if (head_sr_s[ACT_BIT]) begin
        act_nxt_s[head_ir_s] = 1'b1;
      end else begin
        noact_nxt_s[head_ir_s] = 1'b1;
      end
    end else begin
      act_nxt_s   = '0;
      noact_nxt_s = '0;
    end
  end

  // Registered strobes, held command word and sticky overflow (set beats clear)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_if.take_action    <= '0;
      cmd_if.take_no_action <= '0;
      cmd_if.jdo            <= '0;
      cmd_if.jir            <= '0;
      cmd_if.overflow       <= 1'b0;
    end else begin
      cmd_if.take_action    <= act_nxt_s;
      cmd_if.take_no_action <= noact_nxt_s;
      if (pop_s) begin
        cmd_if.jdo <= head_sr_s;
        cmd_if.jir <= head_ir_s;
      end
      if (drop_s) begin
        cmd_if.overflow <= 1'b1;
      end else if (cmd_if.overflow_clr) begin
        cmd_if.overflow <= 1'b0;
      end
    end
  end

  assign cmd_if.cmd_valid  = ~empty_s;
  assign cmd_if.fifo_level = level_s;

endmodule

// File: tb/tb_debug_cmd_sysclk_bridge.sv
// Randomised scoreboard bench for debug_cmd_sysclk_bridge with a queue-level reference model.
module tb_debug_cmd_sysclk_bridge;
  import debug_cmd_pkg::*;

  localparam int SR_W  = SR_W_DEF;
  localparam int IR_W  = IR_W_DEF;
  localparam int ACT   = ACT_BIT_DEF;
  localparam int DEPTH = FIFO_DEPTH_DEF;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [IR_W-1:0] ir_in = '0;
  logic [SR_W-1:0] sr = '0;
  logic            vs_uir = 1'b0;
  logic            vs_udr = 1'b0;

  debug_cmd_sysclk_bridge_if #(.SR_W(SR_W), .IR_W(IR_W), .FIFO_DEPTH(DEPTH)) bif ();

  debug_cmd_sysclk_bridge dut (
    .clk     (clk),
    .reset_n (reset_n),
    .ir_in   (ir_in),
    .sr      (sr),
    .vs_uir  (vs_uir),
    .vs_udr  (vs_udr),
    .cmd_if  (bif.master)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int rdy_mode = 0;

  // Reference model state: the command queue, popped-command scoreboard, held word
  dbg_cmd_t        mq[$];
  dbg_cmd_t        sb[$];
  dbg_cmd_t        m_c, mon_e;
  logic            m_ovf = 1'b0;
  logic [SR_W-1:0] m_jdo = '0;
  logic [IR_W-1:0] m_jir = '0;
  logic [IR_W-1:0] m_ir_reg = '0;
  logic [IR_W-1:0] m_sel;
  logic [2:0]      hu = 3'b111;
  logic [2:0]      hd = 3'b111;
  logic            m_uev, m_dev, m_pop, m_drop;
  logic [NUM_CMD-1:0] ea, ena;
  logic [LEVEL_W-1:0] exp_level;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Reference model: an input high at edge e-2 and low at e-3 is an event at edge e
  initial forever begin
    @(posedge clk);
    if (!reset_n) begin
      mq.delete();
      sb.delete();
      m_ovf = 1'b0; m_jdo = '0; m_jir = '0; m_ir_reg = '0;
      hu = 3'b111; hd = 3'b111;
    end else begin
      m_uev = hu[1] & ~hu[2];
      m_dev = hd[1] & ~hd[2];
      m_sel = m_uev ? ir_in : m_ir_reg;
      m_pop = (mq.size() > 0) && bif.cmd_ready;
      if (m_pop) begin
        m_c = mq.pop_front();
        sb.push_back(m_c);
        m_jdo = m_c.sr;
        m_jir = m_c.ir;
      end
      m_drop = 1'b0;
      if (m_dev) begin
        if (mq.size() < DEPTH) begin
          m_c.ir = m_sel;
          m_c.sr = sr;
          mq.push_back(m_c);
        end else begin
          m_drop = 1'b1;
        end
      end
      if (m_drop) m_ovf = 1'b1;
      else if (bif.overflow_clr) m_ovf = 1'b0;
      if (m_uev) m_ir_reg = ir_in;
      hu = {hu[1:0], vs_uir};
      hd = {hd[1:0], vs_udr};
    end
  end

  // Monitor: compares status every cycle and pops the scoreboard on each strobe
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      exp_level = LEVEL_W'(mq.size());
      chk("cmd_valid", 64'(bif.cmd_valid), 64'(mq.size() != 0));
      chk("fifo_level", 64'(bif.fifo_level), 64'(exp_level));
      chk("overflow", 64'(bif.overflow), 64'(m_ovf));
      chk("jdo_held", 64'(bif.jdo), 64'(m_jdo));
      chk("jir_held", 64'(bif.jir), 64'(m_jir));
      if (sb.size() == 0) begin
        if (bif.take_action != '0 || bif.take_no_action != '0)
          chk("unexpected_strobe", 64'({bif.take_action, bif.take_no_action}), 64'(0));
      end else begin
        mon_e = sb.pop_front();
        ea = '0; ena = '0;
        if (mon_e.sr[ACT]) ea[mon_e.ir] = 1'b1;
        else ena[mon_e.ir] = 1'b1;
        chk("take_action", 64'(bif.take_action), 64'(ea));
        chk("take_no_action", 64'(bif.take_no_action), 64'(ena));
        chk("strobe_jdo", 64'(bif.jdo), 64'(mon_e.sr));
      end
    end
  end

  // cmd_ready driver, applied after the stimulus has settled in each cycle
  initial forever begin
    @(negedge clk);
    #2;
    case (rdy_mode)
      0:       bif.cmd_ready = 1'b0;
      1:       bif.cmd_ready = 1'b1;
      default: bif.cmd_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic send(input logic [IR_W-1:0] ir, input logic [SR_W-1:0] v, input logic both);
    if (both) begin
      ir_in = ir; sr = v; vs_uir = 1'b1; vs_udr = 1'b1;
      tick($urandom_range(1, 2));
      vs_uir = 1'b0; vs_udr = 1'b0;
      tick(3);
    end else begin
      ir_in = ir; vs_uir = 1'b1; tick(2); vs_uir = 1'b0; tick(3);
      sr = v; vs_udr = 1'b1; tick(2); vs_udr = 1'b0; tick(2);
    end
  endtask

  task automatic directed_cmd(input logic [IR_W-1:0] ir, input logic [SR_W-1:0] v,
                              input logic [NUM_CMD-1:0] eta, input logic [NUM_CMD-1:0] etna);
    int n;
    rdy_mode = 0;
    ir_in = ir; vs_uir = 1'b1; tick(2); vs_uir = 1'b0; tick(3);
    sr = v; vs_udr = 1'b1; n = 0;
    while (!bif.cmd_valid && n < 10) begin tick(1); n++; end
    vs_udr = 1'b0;
    chk("udr_to_valid_cycles", 64'(n), 64'(3));
    rdy_mode = 1; n = 0;
    while (bif.take_action == '0 && bif.take_no_action == '0 && n < 10) begin tick(1); n++; end
    chk("dir_take_action", 64'(bif.take_action), 64'(eta));
    chk("dir_take_no_action", 64'(bif.take_no_action), 64'(etna));
    chk("dir_jdo", 64'(bif.jdo), 64'(v));
    chk("dir_jir", 64'(bif.jir), 64'(ir));
    tick(1);
    chk("strobe_width", 64'({bif.take_action, bif.take_no_action}), 64'(0));
    rdy_mode = 0;
    tick(2);
  endtask

  initial begin
    logic [63:0] r;
    int n;
    bif.cmd_ready = 1'b0;
    bif.overflow_clr = 1'b0;
    reset_n = 1'b0;
    tick(3);
    chk("rst_cmd_valid", 64'(bif.cmd_valid), 64'(0));
    chk("rst_level", 64'(bif.fifo_level), 64'(0));
    chk("rst_overflow", 64'(bif.overflow), 64'(0));
    chk("rst_jdo", 64'(bif.jdo), 64'(0));
    chk("rst_strobes", 64'({bif.take_action, bif.take_no_action}), 64'(0));
    reset_n = 1'b1;
    tick(3);

    directed_cmd(2'd1, 38'h08_0000_00AB, 4'b0010, 4'b0000);
    directed_cmd(2'd3, 38'h07_0000_1234, 4'b0000, 4'b1000);

    // Fill past depth, then a clear coincident with a drop, then a lone clear
    rdy_mode = 0;
    for (int i = 0; i < 5; i++) send(IR_W'(i), SR_W'(64'h08_0000_0100 + i), 1'b0);
    chk("ovf_level", 64'(bif.fifo_level), 64'(4));
    chk("ovf_set", 64'(bif.overflow), 64'(1));
    sr = 38'h08_0000_0ABC; vs_udr = 1'b1; tick(2);
    vs_udr = 1'b0; bif.overflow_clr = 1'b1; tick(1);
    chk("ovf_clr_vs_drop", 64'(bif.overflow), 64'(1));
    tick(1);
    chk("ovf_clr_next", 64'(bif.overflow), 64'(0));
    bif.overflow_clr = 1'b0;
    rdy_mode = 1; tick(10); rdy_mode = 0; tick(2);

    // Full queue: push and pop on the same edge
    for (int i = 0; i < 4; i++) send(IR_W'(3 - i), SR_W'(64'h00_0000_0200 + i), 1'b0);
    chk("full_level", 64'(bif.fifo_level), 64'(4));
    sr = 38'h08_0000_0BEE; vs_udr = 1'b1; tick(2);
    rdy_mode = 1; tick(1);
    rdy_mode = 0;
    chk("full_pushpop_level", 64'(bif.fifo_level), 64'(4));
    chk("full_pushpop_ovf", 64'(bif.overflow), 64'(0));
    vs_udr = 1'b0;
    rdy_mode = 1; tick(10); rdy_mode = 0; tick(2);

    // vs_udr held high across reset release must not push
    vs_udr = 1'b1; reset_n = 1'b0; tick(2); reset_n = 1'b1; tick(6);
    chk("held_udr_no_push", 64'(bif.cmd_valid), 64'(0));
    vs_udr = 1'b0; tick(2);

    // Reset in the middle of operation with two commands queued
    send(2'd2, 38'h08_0000_0011, 1'b0);
    send(2'd0, 38'h00_0000_0022, 1'b0);
    chk("mid_level", 64'(bif.fifo_level), 64'(2));
    reset_n = 1'b0; #1;
    chk("mid_rst_level", 64'(bif.fifo_level), 64'(0));
    chk("mid_rst_valid", 64'(bif.cmd_valid), 64'(0));
    chk("mid_rst_strobes", 64'({bif.take_action, bif.take_no_action}), 64'(0));
    chk("mid_rst_jdo_jir", 64'({bif.jir, bif.jdo}), 64'(0));
    tick(2); reset_n = 1'b1; tick(3);

    // Random traffic with random back-pressure and occasional clears
    rdy_mode = 2;
    repeat (40) begin
      r = {$urandom(), $urandom()};
      bif.overflow_clr = ($urandom_range(0, 7) == 0);
      send(IR_W'($urandom_range(0, 3)), r[SR_W-1:0], ($urandom_range(0, 3) == 0));
    end
    bif.overflow_clr = 1'b0;
    rdy_mode = 1;
    n = 0;
    while ((mq.size() != 0 || sb.size() != 0) && n < 200) begin tick(1); n++; end
    chk("drain_complete", 64'(mq.size() + sb.size()), 64'(0));
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
